// File: rtl/stump_shift_iter.sv
// Multi-cycle shift sequencer for the Stump single-bit shift unit.
// Loops the operand through the external shift unit once per clock for a
// programmable number of steps, giving multi-bit ASR/ROR/RRC without a
// barrel shifter. The shift unit itself stays outside this block.
module stump_shift_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       shift_op,
    input  logic [CNT_W-1:0] amount,
    input  logic             c_in,
    output logic [WIDTH-1:0] sh_operand_A,
    output logic             sh_c_in,
    output logic [1:0]       sh_shift_op,
    input  logic [WIDTH-1:0] sh_shift_out,
    input  logic             sh_c_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_NONE = 2'b00;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;

    // State register and datapath registers, synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would let later lines see updated values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            op    <= OP_NONE;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= operand;
                        op    <= shift_op;
                        cnt   <= amount;
                        // A "none" op passes through with a cleared carry,
                        // matching what the shift unit itself produces.
                        carry <= (shift_op == OP_NONE) ? 1'b0 : c_in;
                    end
                end
                RUN: begin
                    acc   <= sh_shift_out;
                    carry <= sh_c_out;
                    cnt   <= cnt - CNT_ONE;
                end
                default: begin
                    // DONE holds acc/carry so result stays stable.
                end
            endcase
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (shift_op == OP_NONE || amount == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: shift unit is only told to shift while in RUN.
    always_comb begin
        sh_operand_A = acc;
        sh_c_in      = carry;
        sh_shift_op  = (state == RUN) ? op : OP_NONE;
        busy         = (state != IDLE);
        done         = (state == DONE);
        result       = acc;
        c_out        = carry;
    end

endmodule
